// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Defining CLA_PIPE_FLAGS_EN adds registered zero/ovf result flags.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  typedef struct packed {
    logic [SW-1:0] s;
    logic          co;
  } slice_t;

  // One slice: 4-bit groups produce group generate/propagate, group carries
  // are resolved across the slice, then bit carries are rebuilt inside each group.
  function automatic slice_t cla_slice(input logic [SW-1:0] x,
                                       input logic [SW-1:0] y,
                                       input logic          ci);
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW:0]   c;
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic [NG:0]   gc;
    slice_t        r;
    p     = x ^ y;
    g     = x & y;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gp[j]   = &p[4*j +: 4];
      gg[j]   = g[4*j+3]
              | (p[4*j+3] & g[4*j+2])
              | ((&p[4*j+2 +: 2]) & g[4*j+1])
              | ((&p[4*j+1 +: 3]) & g[4*j]);
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j] = gc[j];
      for (int i = 1; i < 4; i++)
        c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
    end
    c[SW] = gc[NG];
    r.s   = p ^ c[SW-1:0];
    r.co  = c[SW];
    return r;
  endfunction

  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;       // lowest bit resolved by this stage
    localparam int RW = WIDTH - LO;   // operand bits still unresolved on entry

    logic [RW-1:0]    opa_in;
    logic [RW-1:0]    opb_in;
    logic             cry_in;
    logic             vld_in;
    logic [LO+SW-1:0] sum_d;
    slice_t           res;

    logic             vld_p;
    logic             cry_p;
    logic [LO+SW-1:0] sum_p;

    if (k == 0) begin : src
      assign opa_in = a;
      assign opb_in = b ^ {WIDTH{sub}};
      assign cry_in = sub | cin;
      assign vld_in = in_valid;
      assign sum_d  = res.s;
    end else begin : src
      assign opa_in = stg[k-1].pend.opa_p;
      assign opb_in = stg[k-1].pend.opb_p;
      assign cry_in = stg[k-1].cry_p;
      assign vld_in = stg[k-1].vld_p;
      assign sum_d  = {res.s, stg[k-1].sum_p};
    end

    assign res = cla_slice(opa_in[SW-1:0], opb_in[SW-1:0], cry_in);

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        cry_p <= 1'b0;
        sum_p <= '0;
      end else if (adv) begin
        vld_p <= vld_in;
        cry_p <= res.co;
        sum_p <= sum_d;
      end
    end

    if (k < STAGES-1) begin : pend
      logic [RW-SW-1:0] opa_p;
      logic [RW-SW-1:0] opb_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_p <= '0;
          opb_p <= '0;
        end else if (adv) begin
          opa_p <= opa_in[RW-1:SW];
          opb_p <= opb_in[RW-1:SW];
        end
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    // Carry into the MSB is propagate ^ sum at that bit, so ovf needs no extra carry tap.
    if (k == STAGES-1) begin : flg
      logic zero_p;
      logic ovf_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_p <= 1'b0;
          ovf_p  <= 1'b0;
        end else if (adv) begin
          zero_p <= (sum_d == '0);
          ovf_p  <= opa_in[SW-1] ^ opb_in[SW-1] ^ res.s[SW-1] ^ res.co;
        end
      end
    end
`endif
  end

  assign out_valid = stg[STAGES-1].vld_p;
  assign sum       = stg[STAGES-1].sum_p;
  assign cout      = stg[STAGES-1].cry_p;
`ifdef CLA_PIPE_FLAGS_EN
  assign zero      = stg[STAGES-1].flg.zero_p;
  assign ovf       = stg[STAGES-1].flg.ovf_p;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: three instances (STAGES = 1, 2, 8) share one stimulus stream.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
  localparam int W  = 32;
  localparam int NI = 3;

  typedef struct packed {
    logic [W-1:0]  s;
    logic          co;
    logic          z;
    logic          v;
    logic [31:0]   acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          cin;
  logic          sub;
  logic          out_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ir [NI];
  logic          ov [NI];
  logic [W-1:0]  sm [NI];
  logic          co [NI];
`ifdef CLA_PIPE_FLAGS_EN
  logic          zf [NI];
  logic          of [NI];
`endif

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   cyc = '0;
  logic          nostall = 1'b1;
  exp_t          q [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s, input logic [31:0] t);
    logic [W:0]   r;
    logic [W-1:0] ye;
    exp_t         e;
    ye    = s ? ~y : y;
    r     = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? 1'b1 : c)};
    e.s   = r[W-1:0];
    e.co  = r[W];
    e.z   = (r[W-1:0] == '0);
    e.v   = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    e.acc = t;
    return e;
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int ST = (i == 0) ? 1 : ((i == 1) ? 2 : 8);

    cla_pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[i]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov[i]),
      .out_ready (out_ready),
      .sum       (sm[i]),
`ifdef CLA_PIPE_FLAGS_EN
      .zero      (zf[i]),
      .ovf       (of[i]),
`endif
      .cout      (co[i])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
        if (ov[i]) begin
          checks++;
          assert (q[i].size() > 0) else begin
            errors++;
            $error("FAIL spurious_out st=%0d observed out_valid=1 with sum=%h, required no pending beat", ST, sm[i]);
          end
          if (q[i].size() > 0) begin
            e = q[i][0];
            checks++;
            assert ({co[i], sm[i]} === {e.co, e.s}) else begin
              errors++;
              $error("FAIL result st=%0d observed cout=%b sum=%h, required cout=%b sum=%h", ST, co[i], sm[i], e.co, e.s);
            end
`ifdef CLA_PIPE_FLAGS_EN
            checks++;
            assert ({zf[i], of[i]} === {e.z, e.v}) else begin
              errors++;
              $error("FAIL flags st=%0d observed zero=%b ovf=%b, required zero=%b ovf=%b", ST, zf[i], of[i], e.z, e.v);
            end
`endif
            if (out_ready) begin
              void'(q[i].pop_front());
              if (nostall) begin
                checks++;
                assert ((cyc - e.acc) === 32'(ST)) else begin
                  errors++;
                  $error("FAIL latency st=%0d observed %0d cycles, required %0d", ST, cyc - e.acc, ST);
                end
              end
            end
          end
        end
        if (in_valid && ir[i]) q[i].push_back(model(a, b, cin, sub, cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    tick();
  endtask

  task automatic drain(input int maxc);
    int n;
    n        = 0;
    in_valid = 1'b0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < maxc) begin
      tick();
      n++;
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      assert (q[i].size() == 0) else begin
        errors++;
        $error("FAIL drain inst=%0d observed %0d beats outstanding, required 0", i, q[i].size());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      assert ({ov[i], co[i], sm[i]} === {1'b0, 1'b0, 32'h0}) else begin
        errors++;
        $error("FAIL reset_state inst=%0d observed valid=%b cout=%b sum=%h, required 0/0/0", i, ov[i], co[i], sm[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      assert (ir[i] === 1'b1) else begin
        errors++;
        $error("FAIL ready_after_reset inst=%0d observed %b, required 1", i, ir[i]);
      end
    end
    tick();

    // basic add, wraparound, back-to-back mixed add/sub
    drive(32'h00000003, 32'h00000005, 1'b0, 1'b0);
    drain(20);
    drive(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drain(20);
    drive(32'h0000ABCD, 32'h00001234, 1'b1, 1'b0);
    drive(32'h00000005, 32'h00000003, 1'b0, 1'b1);
    drive(32'h00000003, 32'h00000005, 1'b0, 1'b1);
    drain(20);

    // signed overflow both directions, sub ignoring cin, then random stream
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drive(32'h80000000, 32'h00000001, 1'b1, 1'b1);
    drive(32'h12345678, 32'h12345678, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++)
      drive($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain(20);

    // backpressure with the pipes full
    nostall = 1'b0;
    for (int n = 0; n < 10; n++)
      drive($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      a        = $urandom();
      b        = $urandom();
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        assert (ir[i] === 1'b0) else begin
          errors++;
          $error("FAIL stall_ready inst=%0d observed in_ready=%b, required 0", i, ir[i]);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    drain(40);
    nostall = 1'b1;

    // asynchronous reset with beats in flight
    drive(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    drive(32'h33333333, 32'h44444444, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      assert (ov[i] === 1'b0) else begin
        errors++;
        $error("FAIL async_reset inst=%0d observed out_valid=%b, required 0", i, ov[i]);
      end
      q[i].delete();
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        assert (ov[i] === 1'b0) else begin
          errors++;
          $error("FAIL stale_after_reset inst=%0d observed out_valid=%b sum=%h, required valid 0", i, ov[i], sm[i]);
        end
      end
    end
    drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
